// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROTATE_EN (enables ROR mode).
package shifter_pkg;

    // Operation encodings carried alongside every word through the pipeline.
    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter level: conditionally shifts by DIST, then registers the
// word together with its valid bit, remaining shift amount and mode.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROTATE_EN (enables ROR mode).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIST  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic [1:0]       out_mode
);

    // Shift-amount bit consumed by this level.
    localparam int BIT = $clog2(DIST);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   shamt_q;
    logic [1:0]       mode_q;

    logic [WIDTH-1:0] data_d;
    logic [SHW-1:0]   shamt_d;
    logic [WIDTH-1:0] shifted;
    mode_t            mode_sel;

    // Fixed-distance shift for the requested mode, applied only when this
    // level's shift-amount bit is set; the consumed bit is cleared.
    always_comb begin
        mode_sel = mode_t'(in_mode);
        shifted  = in_data >> DIST;
        case (mode_sel)
            MODE_LSL: shifted = in_data << DIST;
            MODE_ASR: shifted = $signed(in_data) >>> DIST;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
            MODE_ROR: shifted = (in_data >> DIST) | (in_data << (WIDTH - DIST));
`endif
            // LSR, and mode 11 when rotation is not built in.
            default:  shifted = in_data >> DIST;
        endcase
        data_d       = in_shamt[BIT] ? shifted : in_data;
        shamt_d      = in_shamt;
        shamt_d[BIT] = 1'b0;
    end

    // Stage register: cleared by reset, frozen while the pipeline stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            shamt_q <= '0;
            mode_q  <= '0;
        end else if (en) begin
            valid_q <= in_valid;
            data_q  <= data_d;
            shamt_q <= shamt_d;
            mode_q  <= in_mode;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_shamt = shamt_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: log2(WIDTH) registered levels, largest distance
// first, with a single global stall driven by the output handshake.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROTATE_EN (enables ROR mode;
// without it mode 11 behaves as LSR).
module pipe_barrel_shifter
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Index 0 is the input side; index SHW is the last stage register.
    logic             stg_valid [0:SHW];
    logic [WIDTH-1:0] stg_data  [0:SHW];
    logic [SHW-1:0]   stg_shamt [0:SHW];
    logic [1:0]       stg_mode  [0:SHW];

    logic stall;
    logic unused_tail;

    // Every stage holds while a finished result waits for the consumer, so
    // bubbles keep their position and nothing is overwritten.
    assign stall    = stg_valid[SHW] & ~out_ready;
    assign in_ready = ~stall;

    assign stg_valid[0] = in_valid;
    assign stg_data[0]  = in_data;
    assign stg_shamt[0] = in_shamt;
    assign stg_mode[0]  = in_mode;

    generate
        for (genvar gi = 0; gi < SHW; gi++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << (SHW - 1 - gi)),
                .SHW   (SHW)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (~stall),
                .in_valid  (stg_valid[gi]),
                .in_data   (stg_data[gi]),
                .in_shamt  (stg_shamt[gi]),
                .in_mode   (stg_mode[gi]),
                .out_valid (stg_valid[gi+1]),
                .out_data  (stg_data[gi+1]),
                .out_shamt (stg_shamt[gi+1]),
                .out_mode  (stg_mode[gi+1])
            );
        end
    endgenerate

    assign out_valid = stg_valid[SHW];
    assign out_data  = stg_data[SHW];

    // Shift amount and mode are fully consumed once the last level is done.
    assign unused_tail = ^{stg_shamt[SHW], stg_mode[SHW]};

endmodule

// File: tb/tb_pipe_barrel_shifter.sv
// Directed and randomised checks of pipe_barrel_shifter at WIDTH=8.
// Optional feature macro: PIPE_BARREL_SHIFTER_ROTATE_EN (mode 11 = ROR).
module tb_pipe_barrel_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_shamt;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_barrel_shifter #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straightforward whole-word reference shift.
    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] s,
                                             input logic [1:0] m);
        logic [15:0] dd;
        dd = {d, d};
        case (m)
            2'b01: return d << s;
            2'b10: return $signed(d) >>> s;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
            2'b11: return dd[7:0] == d ? 8'(dd >> s) : 8'h00;
`endif
            default: return d >> s;
        endcase
    endfunction

    // Drives one word with out_ready high and returns the result and the
    // number of rising edges from acceptance (inclusive) to out_valid.
    task automatic send_single(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m,
                               output logic [7:0] got, output int lat, output logic rdy);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
        rdy      = in_ready;
        @(posedge clk);
        lat = 1;
        #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        got = out_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end else $display("reset out_valid ok");
        n_checks++;
        if (out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_data: got %h expected 00", out_data);
        end else $display("reset out_data ok");
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end else $display("reset in_ready ok");
    endtask

    task automatic test_directed;
        logic [7:0] d_v   [9];
        logic [2:0] s_v   [9];
        logic [1:0] m_v   [9];
        logic [7:0] exp_v [9];
        logic [7:0] got;
        int         lat;
        logic       rdy;
        d_v[0] = 8'h10; s_v[0] = 3'd4; m_v[0] = 2'b00; exp_v[0] = 8'h01;
        d_v[1] = 8'h01; s_v[1] = 3'd7; m_v[1] = 2'b01; exp_v[1] = 8'h80;
        d_v[2] = 8'h80; s_v[2] = 3'd2; m_v[2] = 2'b10; exp_v[2] = 8'hE0;
        d_v[3] = 8'h40; s_v[3] = 3'd2; m_v[3] = 2'b10; exp_v[3] = 8'h10;
        d_v[4] = 8'hA5; s_v[4] = 3'd0; m_v[4] = 2'b00; exp_v[4] = 8'hA5;
        d_v[5] = 8'hA5; s_v[5] = 3'd0; m_v[5] = 2'b01; exp_v[5] = 8'hA5;
        d_v[6] = 8'hA5; s_v[6] = 3'd0; m_v[6] = 2'b10; exp_v[6] = 8'hA5;
        d_v[7] = 8'hA5; s_v[7] = 3'd0; m_v[7] = 2'b11; exp_v[7] = 8'hA5;
        d_v[8] = 8'h81; s_v[8] = 3'd1; m_v[8] = 2'b11;
`ifdef PIPE_BARREL_SHIFTER_ROTATE_EN
        exp_v[8] = 8'hC0;
`else
        exp_v[8] = 8'h40;
`endif
        for (int i = 0; i < 9; i++) begin
            send_single(d_v[i], s_v[i], m_v[i], got, lat, rdy);
            n_checks++;
            if (got !== exp_v[i] || lat != 3 || rdy !== 1'b1) begin
                n_fail++;
                $display("FAIL directed_%0d: data %h mode %b shamt %0d got %h lat %0d rdy %b expected %h lat 3 rdy 1",
                         i, d_v[i], m_v[i], s_v[i], got, lat, rdy, exp_v[i]);
            end else
                $display("directed_%0d: %h mode %b shamt %0d -> %h lat %0d", i, d_v[i], m_v[i], s_v[i], got, lat);
        end
    endtask

    task automatic test_stall;
        logic [7:0] d_v   [3];
        logic [2:0] s_v   [3];
        logic [1:0] m_v   [3];
        logic [7:0] exp_v [3];
        logic [7:0] got_v [$];
        d_v[0] = 8'h10; s_v[0] = 3'd4; m_v[0] = 2'b00; exp_v[0] = 8'h01;
        d_v[1] = 8'h01; s_v[1] = 3'd7; m_v[1] = 2'b01; exp_v[1] = 8'h80;
        d_v[2] = 8'h80; s_v[2] = 3'd2; m_v[2] = 2'b10; exp_v[2] = 8'hE0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = d_v[i];
            in_shamt = s_v[i];
            in_mode  = m_v[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== exp_v[0]) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: in_ready %b out_valid %b out_data %h expected 0 1 %h",
                         c, in_ready, out_valid, out_data, exp_v[0]);
            end else $display("stall cycle %0d holds %h", c, out_data);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) got_v.push_back(out_data);
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (got_v.size() != 3) begin
            n_fail++;
            $display("FAIL stall_count: got %0d results expected 3", got_v.size());
        end else $display("stall released 3 results");
        for (int i = 0; i < 3 && i < got_v.size(); i++) begin
            n_checks++;
            if (got_v[i] !== exp_v[i]) begin
                n_fail++;
                $display("FAIL stall_order_%0d: got %h expected %h", i, got_v[i], exp_v[i]);
            end else $display("stall result %0d = %h", i, got_v[i]);
        end
    endtask

    task automatic test_mid_reset;
        int stale;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h3C + 8'(i);
            in_shamt = 3'd1;
            in_mode  = 2'b01;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_clear: out_valid %b out_data %h expected 0 00", out_valid, out_data);
        end else $display("mid reset cleared pipeline");
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) stale++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (stale != 0) begin
            n_fail++;
            $display("FAIL mid_reset_stale: got %0d stale results expected 0", stale);
        end else $display("no stale results after reset");
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q [$];
        logic [7:0] cur_d;
        logic [2:0] cur_s;
        logic [1:0] cur_m;
        logic [7:0] e;
        int sent, got, cyc;
        sent  = 0;
        got   = 0;
        cyc   = 0;
        cur_d = 8'($urandom);
        cur_s = 3'($urandom);
        cur_m = 2'($urandom);
        while ((sent < 200 || exp_q.size() > 0) && cyc < 5000) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 200);
            in_data   = cur_d;
            in_shamt  = cur_s;
            in_mode   = cur_m;
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(cur_d, cur_s, cur_m));
                sent++;
                cur_d = 8'($urandom);
                cur_s = 3'($urandom);
                cur_m = 2'($urandom);
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got %h expected no result", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        n_fail++;
                        $display("FAIL b2b_word_%0d: got %h expected %h", got, out_data, e);
                    end else $display("b2b word %0d = %h", got, out_data);
                end
                got++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (got != 200 || sent != 200) begin
            n_fail++;
            $display("FAIL b2b_total: got %0d results from %0d sent expected 200 of 200 (cycles %0d)",
                     got, sent, cyc);
        end else $display("b2b 200 words in %0d cycles", cyc);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
